// File: rtl/cpu_defs.sv
// Shared encodings for the data-memory load/store path.
// Access sizes and the LSU sequencing states.
package cpu_defs;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RSP  = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/dm_lane_mux.sv
// Byte-lane steering between a DM word and a sub-word access.
// Store lanes are merged into the read word; loads are extracted and extended.
module dm_lane_mux
   import cpu_defs::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sext,
   output logic [31:0] merged,
   output logic [31:0] load
);

   logic [7:0]  lb;
   logic [15:0] lh;

   assign lb = word[{off, 3'b000} +: 8];
   assign lh = word[{off[1], 4'b0000} +: 16];

   // Replace only the addressed lane of the captured word.
   always_comb begin
      merged = word;
      unique case (size)
         SIZE_BYTE: merged[{off, 3'b000} +: 8] = wdata[7:0];
         SIZE_HALF: merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default:   merged = wdata;
      endcase
   end

   // Right-justify the addressed lane and extend it.
   always_comb begin
      load = word;
      unique case (size)
         SIZE_BYTE: load = {{24{sext & lb[7]}}, lb};
         SIZE_HALF: load = {{16{sext & lh[15]}}, lh};
         default:   load = word;
      endcase
   end

endmodule

// File: rtl/dm_lsu.sv
// MEM-stage load/store initiator for the word-wide data memory.
// Sub-word stores are done as read-modify-write of the containing word.
module dm_lsu
   import cpu_defs::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sext,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_pc
);

   localparam logic [32:0] LIMIT = 33'(4 * MEM_WORDS);

   lsu_state_t  state;
   logic        we_q;
   logic [1:0]  size_q;
   logic        sext_q;
   logic [1:0]  off_q;
   logic [31:0] wdata_q;

   logic [31:0] rel;
   logic        bad;
   logic [31:0] merged;
   logic [31:0] load;

   assign rel = req_addr - BASE_ADDR;

   // Misalignment, illegal size or outside the implemented DM.
   always_comb begin
      bad = 1'b0;
      unique case (1'b1)
         req_size == 2'd3:
            bad = 1'b1;
         req_size == SIZE_HALF:
            bad = req_addr[0];
         req_size == SIZE_WORD:
            bad = |req_addr[1:0];
         default:
            bad = 1'b0;
      endcase
      if ({1'b0, rel} >= LIMIT)
         bad = 1'b1;
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RSP);
   assign mem_we    = (state == WR);

   dm_lane_mux u_lane (
      .word   (mem_rdata),
      .wdata  (wdata_q),
      .off    (off_q),
      .size   (size_q),
      .sext   (sext_q),
      .merged (merged),
      .load   (load)
   );

   // Access sequencing, request latches and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         size_q    <= SIZE_BYTE;
         sext_q    <= 1'b0;
         off_q     <= 2'b00;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_pc    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  size_q    <= req_size;
                  sext_q    <= req_sext;
                  off_q     <= req_addr[1:0];
                  wdata_q   <= req_wdata;
                  mem_pc    <= req_pc;
                  rsp_rdata <= '0;
                  if (bad) begin
                     rsp_err <= 1'b1;
                     state   <= RSP;
                  end else begin
                     mem_addr <= {req_addr[31:2], 2'b00};
                     if (req_we && req_size == SIZE_WORD) begin
                        mem_wdata <= req_wdata;
                        state     <= WR;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: begin
               if (we_q) begin
                  mem_wdata <= merged;
                  state     <= WR;
               end else begin
                  rsp_rdata <= load;
                  state     <= RSP;
               end
            end
            WR: begin
               state <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_err <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a behavioural word-wide DM.
// Each scenario task checks its own expectations inline.
module tb_dm_lsu;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] mem_pc;

   int checks = 0;
   int errors = 0;

   logic [31:0] dm [0:4095];
   logic        pre_we;
   logic [11:0] pre_idx;
   logic [31:0] pre_data;

   int          we_cnt = 0;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   dm_lsu dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_sext  (req_sext),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_pc    (req_pc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_pc    (mem_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = dm[mem_addr[13:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         dm[mem_addr[13:2]] <= mem_wdata;
         we_cnt  <= we_cnt + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
      end else if (pre_we) begin
         dm[pre_idx] <= pre_data;
      end
   end

   task automatic poke(input logic [11:0] idx, input logic [31:0] d);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = idx;
      pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        output int lat);
      @(negedge clk);
      req_we    = we;
      req_size  = size;
      req_sext  = sext;
      req_addr  = addr;
      req_wdata = wdata;
      req_pc    = pc;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic take();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctl got %b want 1000",
                  {req_ready, rsp_valid, rsp_err, mem_we});
      end
      checks++;
      if ({rsp_rdata, mem_addr, mem_wdata, mem_pc} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data got %h %h %h %h want zeros",
                  rsp_rdata, mem_addr, mem_wdata, mem_pc);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_word_store();
      int lat;
      int w0;
      w0 = we_cnt;
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 32'h100, lat);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL sw_latency got %0d want 2", lat);
      end
      checks++;
      if (we_cnt - w0 !== 1 || wr_addr !== 32'h10 ||
          wr_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL sw_write got n=%0d a=%h d=%h want 1 10 12345678",
                  we_cnt - w0, wr_addr, wr_data);
      end
      checks++;
      if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || mem_pc !== 32'h100) begin
         errors++;
         $display("FAIL sw_rsp got err=%b d=%h pc=%h want 0 0 100",
                  rsp_err, rsp_rdata, mem_pc);
      end
      take();
   endtask

   task automatic test_subword_store();
      int lat;
      int w0;
      logic [1:0]  sz [3]  = '{2'd0, 2'd1, 2'd0};
      logic [31:0] ad [3]  = '{32'h12, 32'h12, 32'h13};
      logic [31:0] wd [3]  = '{32'hAB, 32'hBEEF, 32'hCD};
      logic [31:0] exp [3] = '{32'h12AB_5678, 32'hBEEF_5678, 32'hCDEF_5678};
      poke(12'd4, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         w0 = we_cnt;
         issue(1'b1, sz[i], 1'b0, ad[i], wd[i], 32'h200, lat);
         checks++;
         if (lat !== 3 || we_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL rmw_timing[%0d] got lat=%0d n=%0d want 3 1",
                     i, lat, we_cnt - w0);
         end
         checks++;
         if (wr_data !== exp[i] || dm[4] !== exp[i] || wr_addr !== 32'h10) begin
            errors++;
            $display("FAIL rmw_data[%0d] got %h/%h @%h want %h @10",
                     i, wr_data, dm[4], wr_addr, exp[i]);
         end
         take();
      end
   endtask

   task automatic test_loads();
      int lat;
      int w0;
      logic [1:0]  sz [6]  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
      logic        sx [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] ad [6]  = '{32'h22, 32'h22, 32'h22, 32'h20, 32'h20, 32'h21};
      logic [31:0] exp [6] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0,
                               32'h80F0_7F01, 32'h0000_7F01, 32'h0000_007F};
      poke(12'd8, 32'h80F0_7F01);
      for (int i = 0; i < 6; i++) begin
         w0 = we_cnt;
         issue(1'b0, sz[i], sx[i], ad[i], 32'hDEAD_BEEF, 32'h300, lat);
         checks++;
         if (lat !== 2 || we_cnt !== w0 || rsp_err !== 1'b0 ||
             rsp_rdata !== exp[i]) begin
            errors++;
            $display("FAIL load[%0d] got lat=%0d we=%0d err=%b d=%h want 2 0 0 %h",
                     i, lat, we_cnt - w0, rsp_err, rsp_rdata, exp[i]);
         end
         take();
      end
   endtask

   task automatic test_errors();
      int lat;
      int w0;
      logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
      logic [31:0] ad [4] = '{32'h21, 32'h13, 32'h10, 32'h4000};
      for (int i = 0; i < 4; i++) begin
         w0 = we_cnt;
         issue(we[i], sz[i], 1'b1, ad[i], 32'hFFFF_FFFF, 32'h400, lat);
         checks++;
         if (lat !== 1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
             we_cnt !== w0) begin
            errors++;
            $display("FAIL err[%0d] got lat=%0d err=%b d=%h we=%0d want 1 1 0 0",
                     i, lat, rsp_err, rsp_rdata, we_cnt - w0);
         end
         take();
         checks++;
         if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_clear[%0d] got err=%b v=%b want 0 0",
                     i, rsp_err, rsp_valid);
         end
      end
      w0 = we_cnt;
      issue(1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hCAFE_F00D, 32'h404, lat);
      checks++;
      if (lat !== 2 || rsp_err !== 1'b0 || we_cnt - w0 !== 1 ||
          dm[4095] !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL top_word got lat=%0d err=%b n=%0d d=%h want 2 0 1 cafef00d",
                  lat, rsp_err, we_cnt - w0, dm[4095]);
      end
      take();
   endtask

   task automatic test_backpressure();
      int lat;
      int w0;
      issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h500, lat);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h30;
      req_wdata = 32'h5555_5555;
      req_pc    = 32'h504;
      w0 = we_cnt;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80F0_7F01 ||
             req_ready !== 1'b0 || mem_pc !== 32'h500) begin
            errors++;
            $display("FAIL hold[%0d] got v=%b d=%h rdy=%b pc=%h want 1 80f07f01 0 500",
                     i, rsp_valid, rsp_rdata, req_ready, mem_pc);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      take();
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || we_cnt !== w0) begin
         errors++;
         $display("FAIL release got v=%b rdy=%b we=%0d want 1-idle",
                  rsp_valid, req_ready, we_cnt - w0);
      end
      // back-to-back: accept again right after the handshake cycle
      issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h508, lat);
      checks++;
      if (lat !== 2 || rsp_rdata !== 32'hFFFF_80F0) begin
         errors++;
         $display("FAIL b2b got lat=%0d d=%h want 2 ffff80f0", lat, rsp_rdata);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'h50C, lat);
      checks++;
      if (lat !== 2 || rsp_rdata !== 32'h0000_0080) begin
         errors++;
         $display("FAIL b2b2 got lat=%0d d=%h want 2 80", lat, rsp_rdata);
      end
      take();
   endtask

   task automatic test_reset_mid_wr();
      int w0;
      poke(12'd4, 32'h1234_5678);
      w0 = we_cnt;
      @(negedge clk);
      req_we    = 1'b1;
      req_size  = 2'd0;
      req_sext  = 1'b0;
      req_addr  = 32'h12;
      req_wdata = 32'hAB;
      req_pc    = 32'h600;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1) begin
         errors++;
         $display("FAIL wr_reached got we=%b want 1", mem_we);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0) begin
         errors++;
         $display("FAIL async_we got %b want 0", mem_we);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (dm[4] !== 32'h1234_5678 || we_cnt !== w0) begin
         errors++;
         $display("FAIL dm_untouched got %h n=%0d want 12345678 0",
                  dm[4], we_cnt - w0);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got rdy=%b v=%b want 1 0",
                  req_ready, rsp_valid);
      end
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'd0;
      req_sext  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_pc    = '0;
      rsp_ready = 1'b0;
      pre_we    = 1'b0;
      pre_idx   = '0;
      pre_data  = '0;
      for (int i = 0; i < 4096; i++) dm[i] = '0;
      test_reset();
      test_word_store();
      test_subword_store();
      test_loads();
      test_errors();
      test_backpressure();
      test_reset_mid_wr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
